// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD down-counter: state encoding and digit constants.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  localparam int          BCD_W   = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the decrement chain: subtracts the incoming borrow, wrapping 0 -> 9.
module bcd_down_digit
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       borrow_in,
  output logic [3:0] digit_next,
  output logic       borrow_out
);

  logic w_is_zero;

  assign w_is_zero  = (digit == 4'd0);
  assign borrow_out = borrow_in & w_is_zero;

  always_comb begin
    digit_next = digit;
    if (borrow_in) begin
      digit_next = w_is_zero ? BCD_MAX : (digit - 4'd1);
    end
  end

endmodule

// File: rtl/bcd_down_counter.sv
// Multi-digit BCD countdown timer with load/reload register, expiry pulse and optional auto-reload.
module bcd_down_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter bit WRAP   = 1'b0
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_val,
  input  logic                    start,
  input  logic                    en,
  output logic [BCD_W*DIGITS-1:0] count_out,
  output logic                    zero,
  output logic                    done,
  output logic                    busy
);

  localparam int CW = BCD_W * DIGITS;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_count, w_count_nxt;
  logic [CW-1:0]   r_reload, w_reload_nxt;
  logic            r_done, w_done_nxt;
  logic [CW-1:0]   w_count_dec;
  logic [DIGITS:0] w_borrow;
  logic            w_zero;
  logic            w_is_one;
  logic            w_reload_zero;

  function automatic logic [CW-1:0] sanitise(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[i*BCD_W +: BCD_W] > BCD_MAX) r[i*BCD_W +: BCD_W] = BCD_MAX;
    end
    return r;
  endfunction

  // A borrow that ripples out of the top digit means every digit was zero.
  assign w_borrow[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_down_digit u_digit (
      .digit      (r_count[g*BCD_W +: BCD_W]),
      .borrow_in  (w_borrow[g]),
      .digit_next (w_count_dec[g*BCD_W +: BCD_W]),
      .borrow_out (w_borrow[g+1])
    );
  end

  assign w_zero        = w_borrow[DIGITS];
  assign w_is_one      = (r_count == CW'(1));
  assign w_reload_zero = (r_reload == '0);

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_reload_nxt = r_reload;
    w_done_nxt   = 1'b0;
    if (load) begin
      w_count_nxt  = sanitise(load_val);
      w_reload_nxt = sanitise(load_val);
      w_state_nxt  = IDLE;
    end else if (start) begin
      case (r_state)
        IDLE: begin
          if (!w_zero) begin
            w_state_nxt = RUN;
          end else begin
            w_done_nxt  = 1'b1;
            w_state_nxt = WRAP ? RUN : EXPIRED;
          end
        end
        RUN: w_count_nxt = r_reload;
        EXPIRED: begin
          w_count_nxt = r_reload;
          if (w_reload_zero) w_done_nxt  = 1'b1;
          else               w_state_nxt = RUN;
        end
        default: w_state_nxt = IDLE;
      endcase
    end else if (en && (r_state == RUN)) begin
      // Only reachable with auto-reload: the cycle after expiry restarts from reload.
      if (w_zero) begin
        w_count_nxt = r_reload;
        w_done_nxt  = w_reload_zero;
      end else begin
        w_count_nxt = w_count_dec;
        if (w_is_one) begin
          w_done_nxt = 1'b1;
          if (!WRAP) w_state_nxt = EXPIRED;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_reload <= w_reload_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign count_out = r_count;
  assign zero      = w_zero;
  assign done      = r_done;
  assign busy      = (r_state == RUN);

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed bench for bcd_down_counter: 2-digit stop, 3-digit borrow and 2-digit wrap instances.
module tb_bcd_down_counter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       a_load = 0, a_start = 0, a_en = 0;
  logic [7:0] a_val = '0, a_cnt;
  logic       a_zero, a_done, a_busy;

  logic        b_load = 0, b_start = 0, b_en = 0;
  logic [11:0] b_val = '0, b_cnt;
  logic        b_zero, b_done, b_busy;

  logic       c_load = 0, c_start = 0, c_en = 0;
  logic [7:0] c_val = '0, c_cnt;
  logic       c_zero, c_done, c_busy;

  int n_pass  = 0;
  int n_total = 0;

  bcd_down_counter #(.DIGITS(2), .WRAP(1'b0)) u_a (
    .clk(clk), .reset(reset), .load(a_load), .load_val(a_val), .start(a_start), .en(a_en),
    .count_out(a_cnt), .zero(a_zero), .done(a_done), .busy(a_busy));

  bcd_down_counter #(.DIGITS(3), .WRAP(1'b0)) u_b (
    .clk(clk), .reset(reset), .load(b_load), .load_val(b_val), .start(b_start), .en(b_en),
    .count_out(b_cnt), .zero(b_zero), .done(b_done), .busy(b_busy));

  bcd_down_counter #(.DIGITS(2), .WRAP(1'b1)) u_c (
    .clk(clk), .reset(reset), .load(c_load), .load_val(c_val), .start(c_start), .en(c_en),
    .count_out(c_cnt), .zero(c_zero), .done(c_done), .busy(c_busy));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] a_seq [12];
  logic [7:0] c_seq [8];

  initial begin
    a_seq = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
    c_seq = '{8'h02, 8'h01, 8'h00, 8'h03, 8'h02, 8'h01, 8'h00, 8'h03};

    // reset state
    reset = 1; tick(); reset = 0;
    check_eq("rst_cnt",  32'(a_cnt),  32'h0);
    check_eq("rst_zero", 32'(a_zero), 32'h1);
    check_eq("rst_busy", 32'(a_busy), 32'h0);
    check_eq("rst_done", 32'(a_done), 32'h0);

    // basic countdown 12 -> 00
    a_val = 8'h12; a_load = 1; tick(); a_load = 0;
    check_eq("load12", 32'(a_cnt), 32'h12);
    check_eq("load_idle", 32'(a_busy), 32'h0);
    a_start = 1; tick(); a_start = 0;
    check_eq("start_cnt",  32'(a_cnt),  32'h12);
    check_eq("start_busy", 32'(a_busy), 32'h1);
    a_en = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check_eq($sformatf("dn_cnt%0d", i), 32'(a_cnt), 32'(a_seq[i]));
      check_eq($sformatf("dn_done%0d", i), 32'(a_done), (a_seq[i] == 8'h00) ? 32'h1 : 32'h0);
    end
    check_eq("exp_busy", 32'(a_busy), 32'h0);
    check_eq("exp_zero", 32'(a_zero), 32'h1);
    tick();
    check_eq("exp_hold", 32'(a_cnt),  32'h00);
    check_eq("exp_done_pulse", 32'(a_done), 32'h0);
    a_en = 0;

    // EXPIRED + start reloads, then restart while RUN
    a_start = 1; tick(); a_start = 0;
    check_eq("exp_restart_cnt",  32'(a_cnt),  32'h12);
    check_eq("exp_restart_busy", 32'(a_busy), 32'h1);
    a_en = 1; tick(); tick(); a_en = 0;
    check_eq("run_dec2", 32'(a_cnt), 32'h10);
    a_start = 1; a_en = 1; tick(); a_start = 0; a_en = 0;
    check_eq("run_restart", 32'(a_cnt), 32'h12);
    check_eq("run_restart_busy", 32'(a_busy), 32'h1);

    // pause and load-over-start priority
    a_val = 8'h05; a_load = 1; tick(); a_load = 0;
    a_start = 1; tick(); a_start = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("pause%0d", i), 32'(a_cnt), 32'h05);
    end
    check_eq("pause_busy", 32'(a_busy), 32'h1);
    a_val = 8'h30; a_load = 1; a_start = 1; tick(); a_load = 0; a_start = 0;
    check_eq("prio_cnt",  32'(a_cnt),  32'h30);
    check_eq("prio_busy", 32'(a_busy), 32'h0);
    a_en = 1; tick(); a_en = 0;
    check_eq("idle_no_count", 32'(a_cnt), 32'h30);

    // sanitise and zero-start
    a_val = 8'hAF; a_load = 1; tick(); a_load = 0;
    check_eq("sanitise", 32'(a_cnt), 32'h99);
    a_val = 8'h00; a_load = 1; tick(); a_load = 0;
    check_eq("load0_zero", 32'(a_zero), 32'h1);
    check_eq("load0_done", 32'(a_done), 32'h0);
    a_start = 1; tick(); a_start = 0;
    check_eq("z_start_done", 32'(a_done), 32'h1);
    check_eq("z_start_busy", 32'(a_busy), 32'h0);
    tick();
    check_eq("z_start_pulse", 32'(a_done), 32'h0);

    // 3-digit borrow through two digits
    b_val = 12'h100; b_load = 1; tick(); b_load = 0;
    b_start = 1; tick(); b_start = 0;
    b_en = 1; tick();
    check_eq("borrow1", 32'(b_cnt), 32'h099);
    tick(); b_en = 0;
    check_eq("borrow2", 32'(b_cnt), 32'h098);
    check_eq("borrow_done", 32'(b_done), 32'h0);
    b_val = 12'hFA5; b_load = 1; tick(); b_load = 0;
    check_eq("b_sanitise", 32'(b_cnt), 32'h995);

    // wrap mode, period reload+1
    c_val = 8'h03; c_load = 1; tick(); c_load = 0;
    c_start = 1; tick(); c_start = 0;
    check_eq("wrap_start", 32'(c_cnt), 32'h03);
    c_en = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq($sformatf("wrap_cnt%0d", i), 32'(c_cnt), 32'(c_seq[i]));
      check_eq($sformatf("wrap_done%0d", i), 32'(c_done), (c_seq[i] == 8'h00) ? 32'h1 : 32'h0);
    end
    check_eq("wrap_busy", 32'(c_busy), 32'h1);
    c_en = 0;
    c_val = 8'h00; c_load = 1; tick(); c_load = 0;
    c_start = 1; tick(); c_start = 0;
    c_en = 1;
    tick(); check_eq("wrap0_done_a", 32'(c_done), 32'h1);
    tick(); check_eq("wrap0_done_b", 32'(c_done), 32'h1);
    c_en = 0;
    tick(); check_eq("wrap0_pause", 32'(c_done), 32'h0);

    // reset mid-count
    a_val = 8'h47; a_load = 1; tick(); a_load = 0;
    a_start = 1; tick(); a_start = 0;
    check_eq("mid_cnt", 32'(a_cnt), 32'h47);
    reset = 1; a_en = 1; tick(); reset = 0; a_en = 0;
    check_eq("mid_rst_cnt",  32'(a_cnt),  32'h00);
    check_eq("mid_rst_busy", 32'(a_busy), 32'h0);
    check_eq("mid_rst_done", 32'(a_done), 32'h0);
    check_eq("mid_rst_zero", 32'(a_zero), 32'h1);
    a_start = 1; tick(); a_start = 0;
    check_eq("post_rst_done", 32'(a_done), 32'h1);
    check_eq("post_rst_cnt",  32'(a_cnt),  32'h00);
    check_eq("post_rst_busy", 32'(a_busy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
